// File: rtl/spi_sram_responder.sv
// SPI target for the SRAM-style serial protocol (0x02 write, 0x03 read, 24-bit
// address, sequential bytes) backed by an internal byte memory.
module spi_sram_responder #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk,
    input  logic ce,
    input  logic si,
    output logic so,
    output logic busy,
    output logic cmd_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WRITE_DATA,
        ST_READ_DATA,
        ST_IGNORE
    } state_t;

    state_t                  state_q, state_d;
    logic                    sclk_q, ce_q;
    logic [5:0]              cnt_q, cnt_d;
    logic [7:0]              cmd_q, cmd_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [2:0]              bit_q, bit_d;
    logic [6:0]              wsh_q, wsh_d;
    logic [6:0]              rsh_q, rsh_d;
    logic                    so_q, so_d;
    logic                    cmd_err_q, cmd_err_d;
    logic [7:0]              rd_data_q;
    logic                    mem_we;
    logic [7:0]              mem_wdata;
    logic [7:0]              mem [0:DEPTH-1];

    logic       active, rise, fall;
    logic [7:0] cmd_shift;

    assign active    = ce & ce_q;
    assign rise      = active & sclk & ~sclk_q;
    assign fall      = active & ~sclk & sclk_q;
    assign cmd_shift = {cmd_q[6:0], si};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        bit_d     = bit_q;
        wsh_d     = wsh_q;
        rsh_d     = rsh_q;
        so_d      = so_q;
        cmd_err_d = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = {wsh_q, si};

        if (!ce) begin
            state_d = ST_IDLE;
            cnt_d   = 6'd0;
            bit_d   = 3'd0;
            so_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ce_q) begin
                        state_d = ST_CMD;
                        if (rise) begin
                            cmd_d = cmd_shift;
                            cnt_d = 6'd1;
                        end
                    end
                end
                ST_CMD: begin
                    if (rise) begin
                        cmd_d = cmd_shift;
                        cnt_d = cnt_q + 6'd1;
                        if (cnt_q == 6'd7) begin
                            if (cmd_shift == 8'h02 || cmd_shift == 8'h03) begin
                                state_d = ST_ADDR;
                            end else begin
                                state_d   = ST_IGNORE;
                                cmd_err_d = 1'b1;
                            end
                        end
                    end
                end
                ST_ADDR: begin
                    // Shifting 24 bits through an ADDR_WIDTH register keeps only the low bits.
                    if (rise) begin
                        addr_d = {addr_q[ADDR_WIDTH-2:0], si};
                        cnt_d  = cnt_q + 6'd1;
                        if (cnt_q == 6'd31) begin
                            state_d = cmd_q[0] ? ST_READ_DATA : ST_WRITE_DATA;
                            bit_d   = 3'd0;
                        end
                    end
                end
                ST_WRITE_DATA: begin
                    if (rise) begin
                        wsh_d = {wsh_q[5:0], si};
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            mem_we = ~reset;
                            addr_d = addr_q + ADDR_ONE;
                        end
                    end
                end
                ST_READ_DATA: begin
                    // rd_data_q always mirrors mem[addr_q], so a byte boundary fall can
                    // drive bit 7 straight away and step to the next address.
                    if (fall) begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd0) begin
                            so_d   = rd_data_q[7];
                            rsh_d  = rd_data_q[6:0];
                            addr_d = addr_q + ADDR_ONE;
                        end else begin
                            so_d  = rsh_q[6];
                            rsh_d = {rsh_q[5:0], 1'b0};
                        end
                    end
                end
                ST_IGNORE: begin
                    so_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sclk_q    <= 1'b0;
            ce_q      <= 1'b0;
            cnt_q     <= 6'd0;
            cmd_q     <= 8'd0;
            addr_q    <= '0;
            bit_q     <= 3'd0;
            wsh_q     <= 7'd0;
            rsh_q     <= 7'd0;
            so_q      <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sclk_q    <= sclk;
            ce_q      <= ce;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            bit_q     <= bit_d;
            wsh_q     <= wsh_d;
            rsh_q     <= rsh_d;
            so_q      <= so_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    // Contents survive reset; the read port follows the next address continuously.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= mem_wdata;
        end
        rd_data_q <= mem[addr_d];
    end

    assign so      = so_q;
    assign cmd_err = cmd_err_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: doc/spi_sram_responder.md
# spi_sram_responder

- SPI target that answers the SRAM-style serial protocol (0x02 write, 0x03 read, 24-bit address, sequential byte access) from an internal byte memory.
- Used as the on-chip or simulation counterpart of the SPI memory master, so firmware and RTL can run the full serial path without an external SRAM.
- All SPI inputs are generated in the same `clk` domain (sclk = clk/2 from the master). The block edge-detects them directly; there are no synchronizers.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: memory is 2^ADDR_WIDTH bytes. Received address bits above ADDR_WIDTH are ignored.

Ports:
- `clk`  in  1  system clock. All logic is on posedge.
- `reset`  in  1  synchronous, active-high.
- `sclk`  in  1  serial clock from the master, same clock domain.
- `ce`  in  1  chip enable, active-high.
- `si`  in  1  serial data from the master.
- `so`  out  1  serial data to the master, registered.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `cmd_err`  out  1  one-cycle pulse when an unknown command byte completes.

## Operation
- Edge detection uses `sclk_q`/`ce_q`, which are `sclk`/`ce` registered one cycle.
  - Rise = `sclk & !sclk_q`.
  - Fall = `!sclk & sclk_q`.
  - A rise or fall counts only when `ce & ce_q`. The edge on which `ce` itself asserts is never counted.
- Rise events are numbered R1, R2, … within a transaction; fall event Fk follows Rk.
  - R1–R8: command, MSB first.
  - R9–R32: address bits 23..0.
- `si` is sampled on rise events only.
- FSM states: IDLE, CMD, ADDR, WRITE_DATA, READ_DATA, IGNORE.
  - IDLE → CMD when `ce & ce_q`.
  - CMD → ADDR after R8 if the command is 0x02 or 0x03. Otherwise → IGNORE, pulsing `cmd_err` in the cycle after R8.
  - ADDR → WRITE_DATA (cmd 0x02) or READ_DATA (cmd 0x03) after R32.
  - Any state → IDLE in the cycle after `ce` is seen low, with `so` = 0.
  - IGNORE holds until `ce` drops. `so` stays 0.
- Write path:
  - Data bits are shifted in on R33 onward, MSB first.
  - Each 8th data bit (R40, R48, …) writes mem[addr] and increments addr.
  - A partial byte at `ce` deassert is discarded.
- Read path:
  - The byte at mem[addr] is loaded into the output shifter after R32.
  - Bit 7 is driven on `so` at F32. Each later fall shifts out the next bit.
  - After bit 0 of a byte, the next fall drives bit 7 of mem[addr+1], and so on.
  - R33 is the dummy cycle: `si` is ignored.
  - The master samples `so` at its falls F33, F34, …, so byte k bit b appears at F(33+8k+7−b).
- Address arithmetic is modulo 2^ADDR_WIDTH. Sequential access wraps from the top byte to 0.
- Memory contents are not cleared by `reset`.

## Timing
- Reset values: `so` = 0, `busy` = 0, `cmd_err` = 0, FSM = IDLE, bit counter = 0, `sclk_q` = 0, `ce_q` = 0.
- `busy` rises the cycle after `ce & ce_q` is first seen, and falls the cycle after `ce` is seen low.
- `so` updates at the clk edge ending the cycle in which a fall is detected. It is therefore stable for the following low and high sclk phases.
- A memory write completes at the clk edge ending the cycle in which the 8th data-bit rise is detected. A read-back in a later transaction always sees it.
- `reset` mid-transaction forces IDLE on the next edge. The partial byte is dropped, `so` = 0, and no memory write occurs.
- If `ce` falls in the same cycle as a rise, the rise is not counted.
- Simultaneous `reset` and a byte completion: reset wins and no write occurs.

## Test plan
- Write 0x02, addr 0x000010, data 0xDEADBEEF, then read 0x03, addr 0x000010, 32 bits → master captures 0xDEADBEEF. `busy` is high only while `ce` is high.
- Write 1 byte 0xA5 at 0x3FF (ADDR_WIDTH=10), then 2-byte read from 0x3FF → 0xA5 followed by mem[0x000], confirming wrap.
- Address 0xFF0004 with ADDR_WIDTH=10 → accesses byte 0x004, upper bits ignored.
- Command 0x05 → `cmd_err` pulses exactly once, `so` stays 0 for the whole transaction, and memory is unchanged.
- Write 0x11 then 4 extra bits before `ce` drops → only addr gets 0x11 and addr+1 is unchanged.
- Assert `reset` at R20 of a write → no memory change, `busy` = 0 next cycle, and the next transaction decodes normally.
